ysyx_ifu: RTL and testbench



---
 rtl/ysyx_pkg.sv | 20 ++
 rtl/ysyx_ifu.sv | 132 +++++++++++++
 tb/tb_ysyx_ifu.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_pkg.sv
// Shared fetch/decode types and constants.
// Used by the instruction fetch unit and the decoder.
package ysyx_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } ifu_out_t;

endpackage

// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding fetch, one held instruction.
// Redirects kill stale fetches; misaligned targets become a fault packet.
module ysyx_ifu
  import ysyx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  fetch_state_e state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  req_addr, req_addr_n;
  logic         drop, drop_n;
  logic         mis, mis_n;
  logic         oval, oval_n;
  ifu_out_t     out_q, out_n;
  logic         req_fire;
  logic         redir_mis;

  assign imem_req_valid = (state == S_REQ) & ~rst;
  assign imem_req_addr  = req_addr;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign redir_mis      = |redirect_pc[1:0];

  assign out_valid = oval;
  assign out_inst  = out_q.inst;
  assign out_pc    = out_q.pc;
  assign out_fault = out_q.fault;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    drop_n     = drop;
    mis_n      = mis;
    oval_n     = oval;
    out_n      = out_q;
    unique case (state)
      S_REQ: begin
        if (req_fire) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop) begin
            drop_n = 1'b0;
            if (mis) begin
              state_n = S_OUT;
              oval_n  = 1'b1;
              out_n   = '{inst: NOP_INST, pc: pc, fault: 1'b1};
            end else begin
              state_n    = S_REQ;
              req_addr_n = pc;
              pc_n       = pc + 32'd4;
            end
          end else begin
            state_n = S_OUT;
            oval_n  = 1'b1;
            out_n   = '{inst:  imem_resp_err ? NOP_INST : imem_resp_data,
                        pc:    req_addr,
                        fault: imem_resp_err};
          end
        end
      end
      S_OUT: begin
        // A misaligned-target fault parks here until the next redirect
        if (oval & out_ready) begin
          oval_n = 1'b0;
          if (!mis) begin
            state_n    = S_REQ;
            req_addr_n = pc;
            pc_n       = pc + 32'd4;
          end
        end
      end
      default: state_n = S_REQ;
    endcase

    if (redirect_valid) begin
      mis_n = redir_mis;
      pc_n  = redirect_pc;
      if (state == S_OUT || (state == S_WAIT && imem_resp_valid)) begin
        drop_n = 1'b0;
        if (redir_mis) begin
          state_n = S_OUT;
          oval_n  = 1'b1;
          out_n   = '{inst: NOP_INST, pc: redirect_pc, fault: 1'b1};
        end else begin
          state_n    = S_REQ;
          oval_n     = 1'b0;
          req_addr_n = redirect_pc;
          pc_n       = redirect_pc + 32'd4;
        end
      end else begin
        drop_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC + 32'd4;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
      mis      <= 1'b0;
      oval     <= 1'b0;
      out_q    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      drop     <= drop_n;
      mis      <= mis_n;
      oval     <= oval_n;
      out_q    <= out_n;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu.sv
// Scoreboard bench for ysyx_ifu: directed stimulus, queued expectations,
// independent monitor and a simple instruction memory model.
module tb_ysyx_ifu;
  import ysyx_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ysyx_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_fault       (out_fault),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] exp_req[$];
  ifu_out_t    exp_out[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          tmo = 0;
  bit          done = 1'b0;
  int          lat = 0;
  logic [31:0] err_addr = 32'h0000_0001;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0010_0093;
      32'h8000_0004: return 32'h0020_0113;
      32'h8000_0008: return 32'hDEAD_BEEF;
      32'h8000_0100: return 32'h0050_0293;
      32'h8000_0104: return 32'h0060_0313;
      32'h8000_0300: return 32'h0070_0393;
      32'h8000_0400: return 32'h0080_0413;
      32'h8000_0404: return 32'h0090_0493;
      32'h8000_0200: return 32'h00A0_0513;
      32'hFFFF_FFFC: return 32'h00B0_0593;
      default:       return 32'h0000_0033;
    endcase
  endfunction

  // Memory: response lat cycles after the one following the handshake
  initial begin
    logic        hs_now;
    logic [31:0] a_now;
    logic        pend;
    logic [31:0] paddr;
    int          wcnt;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
    pend = 1'b0;
    paddr = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      hs_now = imem_req_valid && imem_req_ready && !rst;
      a_now  = imem_req_addr;
      @(posedge clk);
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_err   = 1'b0;
      if (rst) pend = 1'b0;
      if (pend) begin
        if (wcnt == 0) begin
          pend = 1'b0;
          imem_resp_valid = 1'b1;
          imem_resp_err   = (paddr == err_addr);
          imem_resp_data  = imem_resp_err ? 32'hFFFF_FFFF : mem_data(paddr);
        end else begin
          wcnt = wcnt - 1;
        end
      end
      if (hs_now) begin
        paddr = a_now;
        if (lat == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_err   = (paddr == err_addr);
          imem_resp_data  = imem_resp_err ? 32'hFFFF_FFFF : mem_data(paddr);
        end else begin
          pend = 1'b1;
          wcnt = lat - 1;
        end
      end
    end
  end

  function automatic void chk(input string nm, input logic [64:0] act,
                              input logic [64:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endfunction

  // Monitor
  initial begin
    logic        p_rst;
    logic        p_req_hold;
    logic [31:0] p_addr;
    logic        p_out_hold;
    ifu_out_t    p_out;
    ifu_out_t    cur;
    p_rst = 1'b1;
    p_req_hold = 1'b0;
    p_addr = '0;
    p_out_hold = 1'b0;
    p_out = '0;
    forever begin
      @(negedge clk);
      cur = '{inst: out_inst, pc: out_pc, fault: out_fault};
      if (done) begin
        chk("req_queue_left", 65'(exp_req.size()), 65'd0);
        chk("out_queue_left", 65'(exp_out.size()), 65'd0);
        chk("timeouts", 65'(tmo), 65'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
      end
      if (rst) begin
        chk("rst_req_valid", 65'(imem_req_valid), 65'd0);
        chk("rst_out_valid", 65'(out_valid), 65'd0);
      end else begin
        if (p_rst) begin
          chk("first_req_valid", 65'(imem_req_valid), 65'd1);
          chk("first_req_addr", 65'(imem_req_addr), 65'h8000_0000);
        end
        if (p_req_hold)
          chk("req_stable", {32'd0, imem_req_valid, imem_req_addr},
              {32'd0, 1'b1, p_addr});
        if (p_out_hold)
          chk("out_stable", {out_valid, cur}, {1'b1, p_out});
        if (imem_req_valid && imem_req_ready) begin
          if (exp_req.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL req_unexpected: got addr %h, expected none",
                     imem_req_addr);
          end else begin
            chk("req_addr", 65'(imem_req_addr), 65'(exp_req.pop_front()));
          end
        end
        if (out_valid && out_ready && !redirect_valid) begin
          if (exp_out.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out_unexpected: got %h, expected none", cur);
          end else begin
            chk("out_inst_pc_fault", cur, exp_out.pop_front());
          end
        end
      end
      p_rst      = rst;
      p_req_hold = imem_req_valid && !imem_req_ready && !rst;
      p_addr     = imem_req_addr;
      p_out_hold = out_valid && !out_ready && !redirect_valid && !rst;
      p_out      = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant();
    int n = 0;
    while (!imem_req_valid && n < 30) begin
      step();
      n++;
    end
    if (!imem_req_valid) begin
      tmo++;
      $display("FAIL grant_timeout: got req_valid 0, expected 1");
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    if (!out_valid) begin
      tmo++;
      $display("FAIL out_timeout: got out_valid 0, expected 1");
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    rst = 1'b0;

    // reset and first fetch
    exp_req.push_back(32'h8000_0000);
    exp_out.push_back('{32'h0010_0093, 32'h8000_0000, 1'b0});
    grant();
    wait_out();
    consume();

    // request then output backpressure
    exp_req.push_back(32'h8000_0004);
    exp_out.push_back('{32'h0020_0113, 32'h8000_0004, 1'b0});
    repeat (3) step();
    grant();
    wait_out();
    repeat (4) step();
    consume();

    // redirect while waiting, response one cycle later
    exp_req.push_back(32'h8000_0008);
    lat = 1;
    grant();
    redir(32'h8000_0100);
    lat = 0;
    exp_req.push_back(32'h8000_0100);
    exp_out.push_back('{32'h0050_0293, 32'h8000_0100, 1'b0});
    grant();
    wait_out();
    consume();

    // redirect coincident with the response
    exp_req.push_back(32'h8000_0104);
    grant();
    redir(32'h8000_0300);
    exp_req.push_back(32'h8000_0300);
    grant();
    wait_out();

    // redirect in S_OUT with out_ready high
    out_ready = 1'b1;
    redir(32'h8000_0400);
    out_ready = 1'b0;
    exp_req.push_back(32'h8000_0400);
    exp_out.push_back('{32'h0080_0413, 32'h8000_0400, 1'b0});
    grant();
    wait_out();
    consume();

    // misaligned redirect from S_OUT, then stall
    exp_req.push_back(32'h8000_0404);
    grant();
    wait_out();
    exp_out.push_back('{NOP_INST, 32'h8000_0102, 1'b1});
    redir(32'h8000_0102);
    wait_out();
    consume();
    imem_req_ready = 1'b1;
    repeat (5) step();
    imem_req_ready = 1'b0;
    exp_req.push_back(32'h8000_0200);
    exp_out.push_back('{32'h00A0_0513, 32'h8000_0200, 1'b0});
    redir(32'h8000_0200);
    grant();
    wait_out();
    consume();

    // access fault
    err_addr = 32'h8000_0204;
    exp_req.push_back(32'h8000_0204);
    exp_out.push_back('{NOP_INST, 32'h8000_0204, 1'b1});
    grant();
    wait_out();
    consume();

    // redirect in S_REQ to the top word, then wrap
    redir(32'hFFFF_FFFC);
    exp_req.push_back(32'h8000_0208);
    grant();
    exp_req.push_back(32'hFFFF_FFFC);
    exp_out.push_back('{32'h00B0_0593, 32'hFFFF_FFFC, 1'b0});
    grant();
    wait_out();
    consume();
    exp_req.push_back(32'h0000_0000);
    grant();

    repeat (3) step();
    done = 1'b1;
  end

endmodule
